// File: rtl/alu_pkg.sv
// Shared encodings for the execute unit: ALUOp, funct3 codes, internal op set
// and divider sequencing states.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_RUN = 2'd1,
        ST_DIV_FIX = 2'd2
    } div_state_e;

    function automatic op_e decode_op(input logic [1:0] aluop, input logic [2:0] f3,
                                      input logic f7b5, input logic f7b0, input logic opb5);
        op_e op;
        op = OP_ADD;
        if (aluop == ALUOP_SUB) begin
            op = OP_SUB;
        end else if (aluop[1] && opb5 && f7b0) begin
            case (f3)
                F3_MUL:    op = OP_MUL;
                F3_MULH:   op = OP_MULH;
                F3_MULHSU: op = OP_MULHSU;
                F3_MULHU:  op = OP_MULHU;
                F3_DIV:    op = OP_DIV;
                F3_DIVU:   op = OP_DIVU;
                F3_REM:    op = OP_REM;
                default:   op = OP_REMU;
            endcase
        end else if (aluop[1]) begin
            case (f3)
                F3_ADD:  op = (f7b5 && opb5) ? OP_SUB : OP_ADD;
                F3_SLL:  op = OP_SLL;
                F3_SLT:  op = OP_SLT;
                F3_SLTU: op = OP_SLTU;
                F3_XOR:  op = OP_XOR;
                F3_SR:   op = f7b5 ? OP_SRA : OP_SRL;
                F3_OR:   op = OP_OR;
                default: op = OP_AND;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider; operands are made non-negative at start
// and the signs are restored in the FIX cycle.
//   state      | meaning
//   ST_IDLE    | waiting for start
//   ST_DIV_RUN | one shift-subtract step per cycle, count XLEN-1 down to 0
//   ST_DIV_FIX | sign correction, result valid on finish
module mdu_divider
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_signed,
    input  logic            want_rem,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            finish,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    div_state_e      state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem, quo, dvs;
    logic            neg_q, neg_r, sel_rem;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] q_fix, r_fix;

    // diff[XLEN] set means the trial subtraction went negative: restore.
    assign rem_sh = {rem, quo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvs};
    assign q_fix  = neg_q ? -quo : quo;
    assign r_fix  = neg_r ? -rem : rem;
    assign result = sel_rem ? r_fix : q_fix;
    assign busy   = (state != ST_IDLE);
    assign finish = (state == ST_DIV_FIX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rem     <= '0;
                        quo     <= (is_signed && a[XLEN-1]) ? -a : a;
                        dvs     <= (is_signed && b[XLEN-1]) ? -b : b;
                        neg_q   <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
                        neg_r   <= is_signed && a[XLEN-1];
                        sel_rem <= want_rem;
                        count   <= CW'(XLEN - 1);
                        state   <= ST_DIV_RUN;
                    end
                end
                ST_DIV_RUN: begin
                    if (diff[XLEN]) begin
                        rem <= rem_sh[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end else begin
                        rem <= diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end
                    if (count == '0) state <= ST_DIV_FIX;
                    else             count <= count - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_mdu_exec.sv
// Execute stage: internal ALU decode, single-cycle ALU and multiplier, and an
// iterative divider behind a valid/ready handshake.
module alu_mdu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic            opb5,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            done_o
);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    op_e               op;
    logic              accept, is_div, div_signed, div_rem, div_special, div_start;
    logic              b_zero, div_ovf, sa, sb;
    logic [SHW-1:0]    shamt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   alu_res, div_res;
    logic              div_busy, div_finish;

    assign op          = decode_op(ALUOp, funct3, funct7b5, funct7b0, opb5);
    assign accept      = valid_i && ready_o;
    assign ready_o     = !div_busy;
    assign is_div      = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    assign div_signed  = (op == OP_DIV) || (op == OP_REM);
    assign div_rem     = (op == OP_REM) || (op == OP_REMU);
    assign b_zero      = (b_i == '0);
    assign div_ovf     = div_signed && (a_i == MIN_VAL) && (b_i == '1);
    assign div_special = is_div && (b_zero || div_ovf);
    assign div_start   = accept && is_div && !div_special;
    assign shamt       = b_i[SHW-1:0];

    // Sign/zero-extend both operands to 2*XLEN so one multiplier covers all variants.
    assign sa   = a_i[XLEN-1] && ((op == OP_MULH) || (op == OP_MULHSU));
    assign sb   = b_i[XLEN-1] && (op == OP_MULH);
    assign prod = {{XLEN{sa}}, a_i} * {{XLEN{sb}}, b_i};

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:    alu_res = a_i + b_i;
            OP_SUB:    alu_res = a_i - b_i;
            OP_SLL:    alu_res = a_i << shamt;
            OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            OP_XOR:    alu_res = a_i ^ b_i;
            OP_SRL:    alu_res = a_i >> shamt;
            OP_SRA:    alu_res = $signed(a_i) >>> shamt;
            OP_OR:     alu_res = a_i | b_i;
            OP_AND:    alu_res = a_i & b_i;
            OP_MUL:    alu_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: alu_res = prod[2*XLEN-1:XLEN];
            default: begin
                if (b_zero)       alu_res = div_rem ? a_i : '1;
                else if (div_ovf) alu_res = div_rem ? '0 : MIN_VAL;
            end
        endcase
    end

    mdu_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .is_signed (div_signed),
        .want_rem  (div_rem),
        .a         (a_i),
        .b         (b_i),
        .busy      (div_busy),
        .finish    (div_finish),
        .result    (div_res)
    );

    // Divider is never in FIX while an accept is possible, so the two loads cannot collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_o <= '0;
            zero_o   <= 1'b1;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (div_finish) begin
                result_o <= div_res;
                zero_o   <= (div_res == '0);
                done_o   <= 1'b1;
            end else if (accept && !div_start) begin
                result_o <= alu_res;
                zero_o   <= (alu_res == '0);
                done_o   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu_exec.sv
// Directed-vector bench for alu_mdu_exec with hand-computed expected results.
module tb_alu_mdu_exec;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_i = 1'b0;
    logic [1:0]  ALUOp = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7b5 = 1'b0, funct7b0 = 1'b0, opb5 = 1'b0;
    logic [31:0] a_i = '0, b_i = '0;
    logic        ready_o, zero_o, done_o;
    logic [31:0] result_o;

    int n_chk  = 0;
    int n_fail = 0;

    alu_mdu_exec #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .ALUOp    (ALUOp),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .funct7b0 (funct7b0),
        .opb5     (opb5),
        .a_i      (a_i),
        .b_i      (b_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [1:0] aluop, input logic [2:0] f3, input logic f7b5,
                          input logic f7b0, input logic ob5, input logic [31:0] a,
                          input logic [31:0] b);
        ALUOp = aluop; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; opb5 = ob5;
        a_i = a; b_i = b;
    endtask

    // Issue the currently set op; latency counts edges after the accept edge.
    task automatic run_op(input string tag, input logic [31:0] exp, input int exp_lat,
                          input logic exp_zero);
        int lat;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 0;
        if (exp_lat > 0) check({tag, "_busy_ready"}, {31'b0, ready_o}, 32'd0);
        while (!done_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_done"}, {31'b0, done_o}, 32'd1);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, result_o, exp);
        check({tag, "_zero"}, {31'b0, zero_o}, {31'b0, exp_zero});
        check({tag, "_ready"}, {31'b0, ready_o}, 32'd1);
        @(posedge clk); #1;
        check({tag, "_done_once"}, {31'b0, done_o}, 32'd0);
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_ready", {31'b0, ready_o}, 32'd1);
        check("rst_result", result_o, 32'd0);
        check("rst_zero", {31'b0, zero_o}, 32'd1);
        check("rst_done", {31'b0, done_o}, 32'd0);
        @(posedge clk); #1;

        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7);
        run_op("add", 32'h0000000C, 0, 1'b0);
        set_op(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd3);
        run_op("sub", 32'h00000000, 0, 1'b1);
        set_op(2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h80000000, 32'd4);
        run_op("sra", 32'hF8000000, 0, 1'b0);
        set_op(2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'd4);
        run_op("srl", 32'h08000000, 0, 1'b0);
        set_op(2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1);
        run_op("slt", 32'h00000001, 0, 1'b0);

        set_op(2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mulh", 32'h00000000, 0, 1'b1);
        set_op(2'b10, 3'b011, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mulhu", 32'hFFFFFFFE, 0, 1'b0);
        set_op(2'b10, 3'b010, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd2);
        run_op("mulhsu", 32'hFFFFFFFF, 0, 1'b0);
        set_op(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFFFFFD);
        run_op("mul", 32'hFFFFFFEB, 0, 1'b0);

        set_op(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
        run_op("rem", 32'hFFFFFFFF, 33, 1'b0);
        set_op(2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
        run_op("remu", 32'd2, 33, 1'b0);

        set_op(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd100, 32'd0);
        run_op("divu_by0", 32'hFFFFFFFF, 0, 1'b0);
        set_op(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'd100, 32'd0);
        run_op("rem_by0", 32'd100, 0, 1'b0);
        set_op(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        run_op("div_ovf", 32'h80000000, 0, 1'b0);

        // DIV -7/2 with a held ADD request behind it: the ADD waits, then issues in the done cycle.
        set_op(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
        valid_i = 1'b1;
        @(posedge clk); #1;
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
        lat = 0;
        check("div_ready_first", {31'b0, ready_o}, 32'd0);
        while (!done_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 31) check("div_ready_late", {31'b0, ready_o}, 32'd0);
        end
        check("div_lat", lat, 33);
        check("div_res", result_o, 32'hFFFFFFFD);
        check("div_ready_done", {31'b0, ready_o}, 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("b2b_done", {31'b0, done_o}, 32'd1);
        check("b2b_res", result_o, 32'd2);
        @(posedge clk); #1;
        check("b2b_done_once", {31'b0, done_o}, 32'd0);

        // Reset in the middle of a DIVU.
        set_op(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_ready", {31'b0, ready_o}, 32'd1);
        check("midrst_done", {31'b0, done_o}, 32'd0);
        check("midrst_result", result_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_idle_done", {31'b0, done_o}, 32'd0);
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3);
        run_op("add_after_rst", 32'd5, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
